// File: rtl/crc_pkg.sv
// Shared CRC-8 constants for the serial CRC generator and its users.
// Defaults describe CRC-8/SMBUS: x^8+x^2+x+1, zero initial value.
package crc_pkg;

    localparam int         CRC_WIDTH = 8;
    localparam logic [7:0] CRC_POLY  = 8'h07;
    localparam logic [7:0] CRC_INIT  = 8'h00;

endpackage : crc_pkg

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 generator: one message bit per enabled clock, MSB of each byte first.
// The register accumulates until reset; crc_out is the register itself.
module crc8_serial
    import crc_pkg::*;
#(
    parameter int               WIDTH = CRC_WIDTH,
    parameter logic [WIDTH-1:0] POLY  = CRC_POLY,
    parameter logic [WIDTH-1:0] INIT  = CRC_INIT
) (
    input  logic             en,
    input  logic             clk,
    input  logic             reset,
    input  logic             d_in,
    output logic [WIDTH-1:0] crc_out
);

    logic [WIDTH-1:0] crc_r;
    logic [WIDTH-1:0] crc_next_s;
    logic             fb_s;

    // Next-state: LFSR shift with polynomial feedback, or hold when not enabled
    always_comb begin
        fb_s       = crc_r[WIDTH-1] ^ d_in;
        crc_next_s = crc_r;
        if (en) begin
            crc_next_s = {crc_r[WIDTH-2:0], 1'b0} ^ (fb_s ? POLY : {WIDTH{1'b0}});
        end else begin
            crc_next_s = crc_r;
        end
    end

    // CRC register; reset wins over a simultaneous enabled bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_r <= INIT;
        end else begin
            crc_r <= crc_next_s;
        end
    end

    assign crc_out = crc_r;

endmodule : crc8_serial

// File: tb/tb_crc8_serial.sv
// Self-checking bench for crc8_serial: directed vectors plus a randomized run
// compared against a GF(2) long-division model of the message polynomial.
module tb_crc8_serial;
    import crc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       d_in;
    logic [7:0] crc_out;
    logic [7:0] crc_out_ff;

    int checks = 0;
    int errors = 0;
    bit msg[$];

    always #5 clk = ~clk;

    crc8_serial dut (
        .en      (en),
        .clk     (clk),
        .reset   (reset),
        .d_in    (d_in),
        .crc_out (crc_out)
    );

    crc8_serial #(.INIT(8'hFF)) dut_ff (
        .en      (en),
        .clk     (clk),
        .reset   (reset),
        .d_in    (d_in),
        .crc_out (crc_out_ff)
    );

    // Remainder of M(x)*x^8 divided by x^8+x^2+x+1, by schoolbook long division
    function automatic logic [7:0] ref_crc(input bit q[$]);
        logic [8:0] rem;
        logic [8:0] divisor;
        divisor = {1'b1, CRC_POLY};
        rem     = 9'h000;
        foreach (q[k]) begin
            rem = {rem[7:0], q[k]};
            if (rem[8]) rem = rem ^ divisor;
        end
        for (int k = 0; k < 8; k++) begin
            rem = {rem[7:0], 1'b0};
            if (rem[8]) rem = rem ^ divisor;
        end
        return rem[7:0];
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic shift_bit(input logic e, input logic b);
        en   = e;
        d_in = b;
        @(posedge clk);
        #1;
        if (e) msg.push_back(b);
    endtask

    task automatic shift_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) shift_bit(1'b1, v[i]);
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_init00"}, crc_out, 8'h00);
        check({tag, "_initFF"}, crc_out_ff, 8'hFF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        msg.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] snap;
        logic [7:0] ascii [9];
        logic [7:0] a5_only;
        bit         one_byte[$];
        logic       r;
        logic       e;
        logic       b;

        reset = 1'b1;
        en    = 1'b0;
        d_in  = 1'b0;
        #1;
        check("reset_no_edge_00", crc_out, 8'h00);
        check("reset_no_edge_FF", crc_out_ff, 8'hFF);
        @(posedge clk);
        #1;
        reset = 1'b0;

        shift_bit(1'b1, 1'b1);
        check("first_bit_one", crc_out, 8'h07);
        shift_bit(1'b1, 1'b0);
        check("second_bit_zero", crc_out, 8'h0E);

        // Async reset mid-cycle must clear immediately, away from any edge
        reset = 1'b1;
        #1;
        check("async_reset_00", crc_out, 8'h00);
        check("async_reset_FF", crc_out_ff, 8'hFF);
        @(posedge clk);
        #1;
        reset = 1'b0;
        msg.delete();

        shift_byte(8'h01);
        check("byte01", crc_out, 8'h07);
        for (int i = 0; i < 5; i++) begin
            shift_bit(1'b0, i[0]);
            check("hold_en0", crc_out, 8'h07);
        end

        // Glitches on d_in/en between edges have no effect
        snap = crc_out;
        en   = 1'b1;
        d_in = 1'b1;
        #2;
        d_in = 1'b0;
        #1;
        en   = 1'b0;
        #1;
        check("between_edges", crc_out, snap);

        pulse_reset("pre_ascii");
        ascii = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        foreach (ascii[i]) shift_byte(ascii[i]);
        check("check_123456789", crc_out, 8'hF4);
        check("model_123456789", crc_out, ref_crc(msg));
        shift_byte(8'hF4);
        check("residue_zero", crc_out, 8'h00);

        pulse_reset("pre_a5");
        shift_bit(1'b1, 1'b1);
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b1, 1'b1);
        shift_bit(1'b1, 1'b0);
        check("partial_a5", crc_out, ref_crc(msg));
        pulse_reset("mid_msg");
        shift_byte(8'hA5);
        one_byte = '{1, 0, 1, 0, 0, 1, 0, 1};
        a5_only  = ref_crc(one_byte);
        check("a5_after_reset", crc_out, a5_only);

        // Reset and enable on the same edge: the bit is discarded
        reset = 1'b1;
        en    = 1'b1;
        d_in  = 1'b1;
        @(posedge clk);
        #1;
        check("reset_vs_en_00", crc_out, 8'h00);
        check("reset_vs_en_FF", crc_out_ff, 8'hFF);
        reset = 1'b0;
        en    = 1'b0;
        msg.delete();
        shift_bit(1'b1, 1'b1);
        check("after_release", crc_out, 8'h07);
        pulse_reset("pre_random");

        for (int i = 0; i < 400; i++) begin
            r     = ($urandom_range(0, 31) == 0);
            e     = 1'($urandom_range(0, 3) != 0);
            b     = 1'($urandom_range(0, 1));
            reset = r;
            en    = e;
            d_in  = b;
            @(posedge clk);
            #1;
            if (r) msg.delete();
            else if (e) msg.push_back(b);
            check("random", crc_out, ref_crc(msg));
            reset = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_crc8_serial
